// File: rtl/tim_pkg.sv
// tim_pkg: shared state encoding and sensor geometry for the CCD timing FSMs
package tim_pkg;

    typedef enum logic [2:0] {
        IDLE, FLUSH, SHUT, EXPOSE, XFER, VSHIFT, HREAD, DONE
    } tim_state_e;

    localparam int NDUM          = 12;
    localparam int NBLA          = 26;
    localparam int NBUF          = 16;
    localparam int NACT          = 2436;
    localparam int NPIX          = NDUM + NBLA + NBUF + NACT;
    localparam int LINE_CLKS_DEF = (NPIX + 1) * 10;

    // A zero exposure still spends one clock in EXPOSE
    function automatic logic [23:0] exp_clamp(input logic [23:0] e);
        return (e == 24'd0) ? 24'd1 : e;
    endfunction

endpackage

// File: rtl/tim_vshift.sv
// tim_vshift: one four-phase vertical shift waveform per go pulse, done on its last cycle
module tim_vshift #(
    parameter int VSHIFT_CLKS = 40
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic go,
    output logic v1,
    output logic v2,
    output logic done
);

    localparam int Q  = VSHIFT_CLKS / 4;
    localparam int CW = $clog2(VSHIFT_CLKS + 1);

    logic          act_q, act_d;
    logic [CW-1:0] c_q, c_d;
    logic          v1_q, v1_d, v2_q, v2_d;

    assign done = act_q && (c_q == CW'(VSHIFT_CLKS - 1));
    assign v1   = v1_q;
    assign v2   = v2_q;

    // Phase counter and registered phase outputs; go restarts the waveform, even back-to-back
    always_comb begin
        act_d = act_q && !done;
        c_d   = act_d ? c_q + 1'b1 : '0;
        if (go) begin
            act_d = 1'b1;
            c_d   = '0;
        end
        if (clr) begin
            act_d = 1'b0;
            c_d   = '0;
        end
        v1_d = act_d && (c_d < CW'(2 * Q));
        v2_d = !act_d || (c_d < CW'(Q)) || (c_d >= CW'(3 * Q));
    end

    // State register; rest levels are v1=0, v2=1
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            act_q <= 1'b0;
            c_q   <= '0;
            v1_q  <= 1'b0;
            v2_q  <= 1'b1;
        end else begin
            act_q <= act_d;
            c_q   <= c_d;
            v1_q  <= v1_d;
            v2_q  <= v2_d;
        end
    end

endmodule

// File: rtl/tim_vfsm.sv
// tim_vfsm: vertical/frame timing controller; optional 2x vertical binning with TIM_VFSM_VBIN2_EN
module tim_vfsm
    import tim_pkg::*;
#(
    parameter int LINE_CLKS   = LINE_CLKS_DEF,
    parameter int NLINES      = 1636,
    parameter int VSHIFT_CLKS = 40,
    parameter int FLUSH_LINES = 16,
    parameter int SUB_CLKS    = 100,
    parameter int TG_CLKS     = 200
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic        abort,
    input  logic [23:0] exp_time,
    output logic        vact,
    output logic        firstline,
    output logic        v1,
    output logic        v2,
    output logic        v2_3,
    output logic        sub,
    output logic        busy,
    output logic        frame_done,
    output logic [11:0] line_idx
);

`ifdef TIM_VFSM_VBIN2_EN
    localparam int   NREAD = NLINES / 2;
    localparam logic BIN2  = 1'b1;
`else
    localparam int   NREAD = NLINES;
    localparam logic BIN2  = 1'b0;
`endif

    tim_state_e  state_q, state_d;
    logic [23:0] cnt_q, cnt_d, exp_q, exp_d;
    logic [15:0] lclk_q, lclk_d;
    logic [11:0] line_q, line_d, fcnt_q, fcnt_d;
    logic        half_q, half_d;
    logic        vact_q, vact_d, first_q, first_d, v2_3_q, v2_3_d;
    logic        sub_q, sub_d, busy_q, busy_d, done_q, done_d;
    logic        go, vs_done, vs_v1, vs_v2;

    tim_vshift #(.VSHIFT_CLKS(VSHIFT_CLKS)) u_vshift (
        .clk  (clk),
        .rst_n(rst_n),
        .clr  (abort),
        .go   (go),
        .v1   (vs_v1),
        .v2   (vs_v2),
        .done (vs_done)
    );

    assign vact       = vact_q;
    assign firstline  = first_q;
    assign v1         = vs_v1;
    assign v2         = vs_v2 | v2_3_q;
    assign v2_3       = v2_3_q;
    assign sub        = sub_q;
    assign busy       = busy_q;
    assign frame_done = done_q;
    assign line_idx   = line_q;

    // Next state, counters and outputs; outputs follow the state being entered
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        exp_d   = exp_q;
        lclk_d  = lclk_q;
        line_d  = line_q;
        fcnt_d  = fcnt_q;
        half_d  = half_q;
        go      = 1'b0;
        if (abort) begin
            state_d = IDLE;
            cnt_d   = '0;
            exp_d   = '0;
            lclk_d  = '0;
            line_d  = '0;
            fcnt_d  = '0;
            half_d  = 1'b0;
        end else begin
            case (state_q)
                IDLE: if (start) begin
                    state_d = FLUSH;
                    exp_d   = exp_clamp(exp_time);
                    fcnt_d  = '0;
                    go      = 1'b1;
                end
                FLUSH: if (vs_done) begin
                    if (fcnt_q == 12'(FLUSH_LINES - 1)) begin
                        state_d = SHUT;
                        fcnt_d  = '0;
                        cnt_d   = '0;
                    end else begin
                        fcnt_d = fcnt_q + 12'd1;
                        go     = 1'b1;
                    end
                end
                SHUT: begin
                    cnt_d   = (cnt_q == 24'(SUB_CLKS - 1)) ? '0 : cnt_q + 24'd1;
                    state_d = (cnt_q == 24'(SUB_CLKS - 1)) ? EXPOSE : SHUT;
                end
                EXPOSE: begin
                    cnt_d   = (cnt_q == exp_q - 24'd1) ? '0 : cnt_q + 24'd1;
                    state_d = (cnt_q == exp_q - 24'd1) ? XFER : EXPOSE;
                end
                XFER: if (cnt_q == 24'(TG_CLKS - 1)) begin
                    state_d = VSHIFT;
                    cnt_d   = '0;
                    line_d  = '0;
                    half_d  = 1'b0;
                    go      = 1'b1;
                end else begin
                    cnt_d = cnt_q + 24'd1;
                end
                VSHIFT: if (vs_done) begin
                    if (BIN2 && !half_q) begin
                        half_d = 1'b1;
                        go     = 1'b1;
                    end else begin
                        state_d = HREAD;
                        half_d  = 1'b0;
                        lclk_d  = '0;
                    end
                end
                HREAD: if (lclk_q == 16'(LINE_CLKS - 1)) begin
                    lclk_d = '0;
                    if (line_q == 12'(NREAD - 1)) begin
                        state_d = DONE;
                    end else begin
                        state_d = VSHIFT;
                        line_d  = line_q + 12'd1;
                        go      = 1'b1;
                    end
                end else begin
                    lclk_d = lclk_q + 16'd1;
                end
                DONE: begin
                    state_d = IDLE;
                    line_d  = '0;
                end
                default: state_d = IDLE;
            endcase
        end
        vact_d  = (state_d == HREAD);
        first_d = (state_d == HREAD) && (line_d == 12'd0);
        v2_3_d  = (state_d == XFER);
        sub_d   = (state_d == SHUT);
        busy_d  = (state_d != IDLE);
        done_d  = (state_d == DONE);
    end

    // State, counter and output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            exp_q   <= '0;
            lclk_q  <= '0;
            line_q  <= '0;
            fcnt_q  <= '0;
            half_q  <= 1'b0;
            vact_q  <= 1'b0;
            first_q <= 1'b0;
            v2_3_q  <= 1'b0;
            sub_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            exp_q   <= exp_d;
            lclk_q  <= lclk_d;
            line_q  <= line_d;
            fcnt_q  <= fcnt_d;
            half_q  <= half_d;
            vact_q  <= vact_d;
            first_q <= first_d;
            v2_3_q  <= v2_3_d;
            sub_q   <= sub_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

endmodule

// File: tb/tb_tim_vfsm.sv
// tb_tim_vfsm: directed frame-level bench for tim_vfsm with short parameters
module tb_tim_vfsm;

    localparam int LINE = 20;
    localparam int VS   = 8;
    localparam int SUBC = 5;
    localparam int TGC  = 6;
`ifdef TIM_VFSM_VBIN2_EN
    localparam int NREAD = 2;
    localparam int GAP   = 16;
    localparam int L10   = 110;
    localparam int L1    = 101;
    localparam int L7    = 107;
`else
    localparam int NREAD = 4;
    localparam int GAP   = 8;
    localparam int L10   = 150;
    localparam int L1    = 141;
    localparam int L7    = 147;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        abort = 1'b0;
    logic [23:0] exp_time = '0;
    logic        vact, firstline, v1, v2, v2_3, sub, busy, frame_done;
    logic [11:0] line_idx;

    int checks = 0;
    int failures = 0;
    int len, pulses, fl_first, fl_other, bad_w, bad_idx, gmin, gmax, subc, tgc, v1c;

    typedef struct {
        logic [23:0] e;
        int          len;
        int          inj;
    } vec_t;
    vec_t tbl[5];

    tim_vfsm #(
        .LINE_CLKS(LINE), .NLINES(4), .VSHIFT_CLKS(VS),
        .FLUSH_LINES(2), .SUB_CLKS(SUBC), .TG_CLKS(TGC)
    ) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .exp_time(exp_time),
        .vact(vact), .firstline(firstline), .v1(v1), .v2(v2), .v2_3(v2_3), .sub(sub),
        .busy(busy), .frame_done(frame_done), .line_idx(line_idx)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s got=%0d expected=%0d", nm, act, exp);
        end
    endtask

    task automatic chk_rest(input string nm);
        chk({nm, "_vact"}, 32'(vact), 0);
        chk({nm, "_first"}, 32'(firstline), 0);
        chk({nm, "_v1"}, 32'(v1), 0);
        chk({nm, "_v2"}, 32'(v2), 1);
        chk({nm, "_v2_3"}, 32'(v2_3), 0);
        chk({nm, "_sub"}, 32'(sub), 0);
        chk({nm, "_busy"}, 32'(busy), 0);
        chk({nm, "_done"}, 32'(frame_done), 0);
        chk({nm, "_line"}, 32'(line_idx), 0);
    endtask

    task automatic kick(input logic [23:0] e);
        start = 1'b1;
        exp_time = e;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Called at the negedge of frame cycle 1; walks the frame collecting statistics
    task automatic measure(input int inj);
        int w = 0, g = 0;
        logic prev = 1'b0;
        len = 0; pulses = 0; fl_first = 0; fl_other = 0; bad_w = 0; bad_idx = 0;
        gmin = 9999; gmax = 0; subc = 0; tgc = 0; v1c = 0;
        for (int n = 1; n <= 1000; n++) begin
            start = (n == inj);
            if (vact) begin
                if (!prev) begin
                    pulses++;
                    if (pulses > 1) begin
                        gmin = (g < gmin) ? g : gmin;
                        gmax = (g > gmax) ? g : gmax;
                    end
                    w = 0;
                end
                w++;
                if (32'(line_idx) != pulses - 1) bad_idx++;
                if (firstline && pulses == 1) fl_first++;
                else if (firstline) fl_other++;
            end else begin
                if (prev && w != LINE) bad_w++;
                if (prev) g = 0;
                g++;
                if (firstline) fl_other++;
            end
            subc += 32'(sub);
            tgc += 32'(v2_3);
            v1c += 32'(v1);
            prev = vact;
            if (frame_done) begin
                len = n;
                break;
            end
            @(negedge clk);
        end
        start = 1'b0;
    endtask

    task automatic chk_frame(input string nm, input int exp_len);
        chk({nm, "_len"}, len, exp_len);
        chk({nm, "_pulses"}, pulses, NREAD);
        chk({nm, "_first"}, fl_first, LINE);
        chk({nm, "_first_other"}, fl_other, 0);
        chk({nm, "_width"}, bad_w, 0);
        chk({nm, "_line_idx"}, bad_idx, 0);
        chk({nm, "_gap_min"}, gmin, GAP);
        chk({nm, "_gap_max"}, gmax, GAP);
        chk({nm, "_sub"}, subc, SUBC);
        chk({nm, "_tg"}, tgc, TGC);
        chk({nm, "_v1"}, v1c, (2 + 4) * VS / 2);
    endtask

    initial begin
        int w, p, cnt;
        logic prev;
        tbl[0] = '{e: 24'd10, len: L10, inj: -1};
        tbl[1] = '{e: 24'd0,  len: L1,  inj: -1};
        tbl[2] = '{e: 24'd1,  len: L1,  inj: -1};
        tbl[3] = '{e: 24'd7,  len: L7,  inj: -1};
        tbl[4] = '{e: 24'd10, len: L10, inj: 25};

        repeat (2) @(negedge clk);
        chk_rest("reset");
        rst_n = 1'b1;
        @(negedge clk);

        start = 1'b1;
        abort = 1'b1;
        @(negedge clk);
        start = 1'b0;
        abort = 1'b0;
        chk("start_abort_busy", 32'(busy), 0);

        for (int i = 0; i < 5; i++) begin
            kick(tbl[i].e);
            measure(tbl[i].inj);
            chk_frame($sformatf("row%0d", i), tbl[i].len);
            @(negedge clk);
        end

        kick(24'd10);
        measure(-1);
        chk("pre_done_len", len, L10);
        start = 1'b1;
        exp_time = 24'd10;
        @(negedge clk);
        chk("start_on_done_ignored", 32'(busy), 0);
        @(negedge clk);
        start = 1'b0;
        chk("start_after_done_busy", 32'(busy), 1);
        measure(-1);
        chk_frame("late_start", L10);
        @(negedge clk);

        kick(24'd10);
        w = 0; p = 0; prev = 1'b0;
        for (int n = 0; n < 1000; n++) begin
            if (vact) begin
                if (!prev) begin
                    p++;
                    w = 0;
                end
                w++;
            end
            prev = vact;
            if (p == 3 && w == 10) break;
            @(negedge clk);
        end
        chk("abort_reached_line3", p * 100 + w, 310);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        chk_rest("abort");
        cnt = 0;
        for (int n = 0; n < 200; n++) begin
            cnt += 32'(frame_done) + 32'(busy);
            @(negedge clk);
        end
        chk("abort_quiet", cnt, 0);

        kick(24'd10);
        cnt = 0;
        while (!v2_3 && cnt < 500) begin
            cnt++;
            @(negedge clk);
        end
        chk("xfer_reached", 32'(v2_3), 1);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("async_v2_3", 32'(v2_3), 0);
        chk("async_busy", 32'(busy), 0);
        chk("async_v2", 32'(v2), 1);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        kick(24'd10);
        measure(-1);
        chk_frame("post_reset", L10);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
